daq_sample_buffer: RTL and testbench

- Downstream stage of the SPI sensor interface: consumes its one-word-per-frame output (data-ready strobe + data word).
- Decimates by averaging 2^AVG_LOG2 consecutive samples and timestamps each averaged result.
- Queues results in a first-word-fall-through FIFO read by the DAQ host logic through a valid/ready handshake.
- Provides occupancy, sticky overflow and watermark interrupt.

---
 rtl/daq_sample_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_daq_sample_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/daq_sample_buffer.sv
// daq_sample_buffer
// Takes one sample per rising edge of the SPI data-ready strobe.
// Averages 2^AVG_LOG2 samples and tags each result with a free-running timestamp.
// Queues results in a first-word-fall-through FIFO that the host reads with valid/ready.
// Also reports occupancy, a sticky overflow flag and a watermark interrupt.

module daq_sample_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned WATERMARK  = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic                       irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned ACC_W = DATA_WIDTH + AVG_LOG2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_WM   = LVL_W'(WATERMARK);

    // ------------------------------------------------------------------
    // Timestamp and input edge detection
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                vld_prev_q;
    logic                sample_take;

    assign ts_d        = ts_q + TS_WIDTH'(1);
    assign sample_take = in_valid & ~vld_prev_q & enable & ~flush;

    // Free-running timestamp; also remembers the previous in_valid for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            vld_prev_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            vld_prev_q <= in_valid;
        end
    end

    // ------------------------------------------------------------------
    // Averaging accumulator and pending-result register
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [TS_WIDTH-1:0]   pend_ts_q, pend_ts_d;
    logic [ACC_W-1:0]      sum;

    assign sum = acc_q + ACC_W'(in_data);

    // Accumulate accepted samples; on the last one of a group, register the result for the FIFO
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        pend_data_d = pend_data_q;
        pend_ts_d   = pend_ts_q;
        if (flush || !enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_take) begin
            if (cnt_q == CNT_LAST) begin
                acc_d       = '0;
                cnt_d       = '0;
                pend_d      = 1'b1;
                // Top DATA_WIDTH bits of the sum equal sum >> AVG_LOG2
                pend_data_d = sum[ACC_W-1 -: DATA_WIDTH];
                pend_ts_d   = ts_q;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_ts_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_ts_q   <= pend_ts_d;
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;

    logic             fifo_valid;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign fifo_valid = (level_q != '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign pop        = fifo_valid & out_ready & ~flush;
    // A full FIFO still takes a push when a pop frees a slot at the same edge
    assign push_ok    = pend_q & ~flush & (~fifo_full | pop);
    assign drop       = pend_q & ~flush & fifo_full & ~pop;

    // Next pointers, occupancy, overflow and watermark
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        irq_d = (level_d >= LVL_WM);
    end

    // FIFO control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    // Storage array; unread entries are masked at the output, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_q] <= pend_data_q;
            ts_mem[wr_ptr_q]   <= pend_ts_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = fifo_valid;
    assign out_data  = fifo_valid ? data_mem[rd_ptr_q] : '0;
    assign out_ts    = fifo_valid ? ts_mem[rd_ptr_q]   : '0;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_daq_sample_buffer.sv
// Directed bench for daq_sample_buffer.
// One instance averages 4 samples; the other is a passthrough used for FIFO fill/drain cases.

module tb_daq_sample_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // averaging instance (AVG_LOG2=2)
    logic        a_en, a_flush, a_vld, a_rdy, a_clr;
    logic [15:0] a_dat;
    logic        a_ovalid, a_ovf, a_irq;
    logic [15:0] a_odata, a_ots;
    logic [4:0]  a_level;

    // passthrough instance (AVG_LOG2=0)
    logic        p_en, p_flush, p_vld, p_rdy, p_clr;
    logic [15:0] p_dat;
    logic        p_ovalid, p_ovf, p_irq;
    logic [15:0] p_odata, p_ots;
    logic [4:0]  p_level;

    daq_sample_buffer #(
        .DATA_WIDTH(16), .DEPTH(16), .AVG_LOG2(2), .TS_WIDTH(16), .WATERMARK(12)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .flush(a_flush),
        .in_valid(a_vld), .in_data(a_dat),
        .out_valid(a_ovalid), .out_ready(a_rdy), .out_data(a_odata), .out_ts(a_ots),
        .level(a_level), .overflow(a_ovf), .clear_ovf(a_clr), .irq(a_irq)
    );

    daq_sample_buffer #(
        .DATA_WIDTH(16), .DEPTH(16), .AVG_LOG2(0), .TS_WIDTH(16), .WATERMARK(12)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .enable(p_en), .flush(p_flush),
        .in_valid(p_vld), .in_data(p_dat),
        .out_valid(p_ovalid), .out_ready(p_rdy), .out_data(p_odata), .out_ts(p_ots),
        .level(p_level), .overflow(p_ovf), .clear_ovf(p_clr), .irq(p_irq)
    );

    // reference timestamp: cycles since reset release
    logic [15:0] tb_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 16'd1;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] a_ts_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // one-cycle data-ready pulse; returns at the falling edge after the sampling edge
    task automatic pulse_a(input logic [15:0] d, input int gap);
        @(negedge clk);
        a_vld = 1'b1; a_dat = d; a_ts_exp = tb_ts;
        @(negedge clk);
        a_vld = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_p(input logic [15:0] d);
        @(negedge clk);
        p_vld = 1'b1; p_dat = d;
        @(negedge clk);
        p_vld = 1'b0;
    endtask

    task automatic pop_a();
        @(negedge clk); a_rdy = 1'b1;
        @(negedge clk); a_rdy = 1'b0;
    endtask

    task automatic pop_p();
        @(negedge clk); p_rdy = 1'b1;
        @(negedge clk); p_rdy = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_en = 1'b1; a_flush = 1'b0; a_vld = 1'b0; a_rdy = 1'b0; a_clr = 1'b0; a_dat = '0;
        p_en = 1'b1; p_flush = 1'b0; p_vld = 1'b0; p_rdy = 1'b0; p_clr = 1'b0; p_dat = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", a_ovalid, 0);
        check_eq("rst_level", a_level, 0);
        check_eq("rst_irq", p_irq, 0);
        check_eq("rst_ovf", p_ovf, 0);
        rst_n = 1'b1;

        // basic average: (100+101+102+105)/4 = 102
        pulse_a(16'd100, 19);
        pulse_a(16'd101, 19);
        pulse_a(16'd102, 19);
        pulse_a(16'd105, 0);
        check_eq("t1_valid_early", a_ovalid, 0);
        @(negedge clk);
        check_eq("t1_valid", a_ovalid, 1);
        check_eq("t1_data", a_odata, 102);
        check_eq("t1_ts", a_ots, {16'd0, a_ts_exp});
        check_eq("t1_level", a_level, 1);
        pop_a();
        check_eq("t1_empty", a_level, 0);
        check_eq("t1_data_zero", a_odata, 0);
        check_eq("t1_ts_zero", a_ots, 0);

        // held in_valid: 3 cycles high per sample, four samples of 0x10
        for (int g = 0; g < 4; g++) begin
            @(negedge clk); a_vld = 1'b1; a_dat = 16'h0010;
            repeat (3) @(negedge clk);
            a_vld = 1'b0;
            repeat (2) @(negedge clk);
        end
        check_eq("held_level", a_level, 1);
        check_eq("held_data", a_odata, 16'h0010);
        pop_a();

        // partial average dropped by enable=0: 50,50 then 8,8,8,8 -> 8
        pulse_a(16'd50, 1);
        pulse_a(16'd50, 1);
        @(negedge clk); a_en = 1'b0;
        @(negedge clk); a_en = 1'b1;
        for (int i = 0; i < 4; i++) pulse_a(16'd8, 1);
        check_eq("en_level", a_level, 1);
        check_eq("en_data", a_odata, 8);
        pop_a();

        // partial average dropped by flush, which also empties the FIFO
        for (int i = 0; i < 4; i++) pulse_a(16'd20, 0);
        @(negedge clk);
        check_eq("fl_pre_level", a_level, 1);
        check_eq("fl_pre_data", a_odata, 20);
        pulse_a(16'd50, 1);
        pulse_a(16'd50, 1);
        @(negedge clk); a_flush = 1'b1;
        @(negedge clk); a_flush = 1'b0;
        check_eq("fl_level", a_level, 0);
        check_eq("fl_valid", a_ovalid, 0);
        for (int i = 0; i < 4; i++) pulse_a(16'd8, 1);
        check_eq("fl_res_level", a_level, 1);
        check_eq("fl_res_data", a_odata, 8);
        check_eq("fl_ovf", a_ovf, 0);
        pop_a();

        // passthrough: 17 samples with no reads
        for (int k = 1; k <= 17; k++) begin
            pulse_p(16'(k));
            check_eq("fill_level", p_level, (k - 1 > 16) ? 16 : k - 1);
            check_eq("fill_irq", p_irq, (k - 1 >= 12) ? 1 : 0);
        end
        check_eq("fill_ovf_before", p_ovf, 0);
        @(negedge clk);
        check_eq("full_level", p_level, 16);
        check_eq("full_irq", p_irq, 1);
        check_eq("full_ovf", p_ovf, 1);
        for (int k = 1; k <= 16; k++) begin
            check_eq("drain_data", p_odata, k);
            pop_p();
        end
        check_eq("drain_valid", p_ovalid, 0);
        check_eq("drain_irq", p_irq, 0);
        check_eq("drain_ovf_sticky", p_ovf, 1);
        @(negedge clk); p_clr = 1'b1;
        @(negedge clk); p_clr = 1'b0;
        check_eq("clr_ovf", p_ovf, 0);

        // full FIFO with pop and push on the same edge
        for (int k = 101; k <= 116; k++) pulse_p(16'(k));
        @(negedge clk);
        check_eq("sim_pre_level", p_level, 16);
        @(negedge clk); p_vld = 1'b1; p_dat = 16'd117;
        @(negedge clk); p_vld = 1'b0; p_rdy = 1'b1;
        @(negedge clk); p_rdy = 1'b0;
        check_eq("sim_level", p_level, 16);
        check_eq("sim_ovf", p_ovf, 0);
        check_eq("sim_head", p_odata, 102);
        for (int k = 102; k <= 117; k++) begin
            check_eq("sim_drain", p_odata, k);
            pop_p();
        end
        check_eq("sim_empty", p_level, 0);

        // overflow survives flush
        for (int k = 201; k <= 217; k++) pulse_p(16'(k));
        @(negedge clk);
        check_eq("ovf2", p_ovf, 1);
        @(negedge clk); p_flush = 1'b1;
        @(negedge clk); p_flush = 1'b0;
        check_eq("ovf2_flush_level", p_level, 0);
        check_eq("ovf2_flush_irq", p_irq, 0);
        check_eq("ovf2_flush_ovf", p_ovf, 1);
        @(negedge clk); p_clr = 1'b1;
        @(negedge clk); p_clr = 1'b0;
        check_eq("ovf2_clr", p_ovf, 0);

        // asynchronous reset with level 5 and a partial average pending
        for (int g = 0; g < 5; g++)
            for (int i = 0; i < 4; i++) pulse_a(16'(g * 10), 0);
        @(negedge clk);
        check_eq("pre_rst_level", a_level, 5);
        pulse_a(16'd1000, 0);
        pulse_a(16'd1000, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", a_ovalid, 0);
        check_eq("arst_level", a_level, 0);
        check_eq("arst_data", a_odata, 0);
        check_eq("arst_ts", a_ots, 0);
        @(negedge clk); rst_n = 1'b1;
        // samples taken at timestamps 1,3,5,7; (7+8+9+10)/4 = 8
        pulse_a(16'd7, 0);
        pulse_a(16'd8, 0);
        pulse_a(16'd9, 0);
        pulse_a(16'd10, 0);
        @(negedge clk);
        check_eq("post_rst_level", a_level, 1);
        check_eq("post_rst_data", a_odata, 8);
        check_eq("post_rst_ts", a_ots, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
